// File: rtl/serial_sub_if.sv
// serial_sub_if: request/result bundle between a controller and serial_sub.
//   start       : request pulse (sampled by the subtractor only while busy = 0)
//   a, b        : minuend / subtrahend, captured on the accepted start
//   busy        : subtraction in progress
//   done        : one-cycle pulse when diff/borrow are refreshed
//   diff        : a - b modulo 2^WIDTH
//   borrow      : final borrow out (a < b, unsigned)
// master = controller side, slave = subtractor side.
interface serial_sub_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (output start, a, b, input busy, done, diff, borrow);
  modport slave  (input start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/serial_sub.sv
// serial_sub: bit-serial, LSB-first unsigned subtractor, diff = a - b.
// One full-subtractor slice (two half_sub cells + OR) is evaluated per clock
// with the borrow carried between slices in a flip-flop. Operands are captured
// on an accepted start; WIDTH slices later the result is published with a
// one-cycle done pulse.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears every register
//   bus  : serial_sub_if.slave (start/a/b in, busy/done/diff/borrow out)

// half_sub: d = x - y (one bit), bo = borrow out.
module half_sub (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);
  assign d  = x ^ y;
  assign bo = ~x & y;
endmodule

module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  serial_sub_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  // Full-subtractor slice: (x - y) then (- br); either stage may borrow.
  logic d1, b1, d, b2, br_nx;

  half_sub u_hs0 (.x(a_sh[0]), .y(b_sh[0]), .d(d1), .bo(b1));
  half_sub u_hs1 (.x(d1),      .y(br),      .d(d),  .bo(b2));

  assign br_nx = b1 | b2;

  logic last;
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the DONE state raises it.
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            br     <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end

        SHIFT: begin
          // start is ignored here; operands already live in the shifters.
          r_sh <= {d, r_sh[WIDTH-1:1]};
          br   <= br_nx;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
          if (last) begin
            busy_q <= 1'b0;
            state  <= DONE;
          end
        end

        DONE: begin
          // r_sh/br already include the last slice, so publish them now.
          done_q   <= 1'b1;
          diff_q   <= r_sh;
          borrow_q <= br;
          if (bus.start) begin
            // back-to-back: reload without passing through IDLE
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            br     <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end else begin
            state  <= IDLE;
          end
        end

        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
endmodule
